// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, with an optional
// per-owner burst hold and a one-cycle registered write stage.
module regfile_write_arbiter #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 3,
  parameter int MAX_BURST     = 1,
  parameter int ZERO_REG_DROP = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_freeze,
  input  logic [3:0]            i_req,
  input  logic [4*ADDR_W-1:0]   i_req_addr,
  input  logic [4*DATA_W-1:0]   i_req_data,
  output logic [3:0]            o_gnt,
  output logic                  o_wr_en,
  output logic [ADDR_W-1:0]     o_wr_addr,
  output logic [DATA_W-1:0]     o_wr_data,
  output logic [1:0]            o_wr_src
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  logic [1:0]       r_ptr;
  logic [1:0]       r_owner;
  logic             r_owner_vld;
  logic [CNT_W-1:0] r_cnt;

  logic             w_hold;
  logic             w_grant;
  logic [1:0]       w_gnt_idx;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;

  // Scan downwards so the requester closest to r_ptr is the last (winning) assignment.
  always_comb begin
    w_hold    = r_owner_vld && i_req[r_owner] && (r_cnt < CNT_LAST);
    w_grant   = 1'b0;
    w_gnt_idx = r_ptr;
    if (!i_freeze && (i_req != 4'b0000)) begin
      w_grant = 1'b1;
      if (w_hold) begin
        w_gnt_idx = r_owner;
      end else begin
        for (int k = 3; k >= 0; k--) begin
          if (i_req[r_ptr + 2'(k)]) begin
            w_gnt_idx = r_ptr + 2'(k);
          end
        end
      end
    end
  end

  assign o_gnt      = (w_grant && i_rst_n) ? (4'b0001 << w_gnt_idx) : 4'b0000;
  assign w_sel_addr = i_req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
  assign w_sel_data = i_req_data[w_gnt_idx*DATA_W +: DATA_W];

  // Saturate so a lone requester re-won by rotation cannot push cnt past the limit.
  assign w_cnt_inc = (r_cnt == CNT_LAST) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr       <= 2'd0;
      r_owner     <= 2'd0;
      r_owner_vld <= 1'b0;
      r_cnt       <= '0;
    end else if (w_grant) begin
      r_cnt       <= (r_owner_vld && (w_gnt_idx == r_owner)) ? w_cnt_inc : '0;
      r_owner     <= w_gnt_idx;
      r_owner_vld <= 1'b1;
      r_ptr       <= w_gnt_idx + 2'd1;
    end else if (!i_freeze) begin
      r_owner_vld <= 1'b0;
      r_cnt       <= '0;
    end
  end

  // Writes to register 0 are still granted and registered, only the enable is dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_wr_src  <= 2'd0;
    end else if (w_grant) begin
      o_wr_en   <= !((ZERO_REG_DROP != 0) && (w_sel_addr == '0));
      o_wr_addr <= w_sel_addr;
      o_wr_data <= w_sel_data;
      o_wr_src  <= w_gnt_idx;
    end else begin
      o_wr_en <= 1'b0;
    end
  end

endmodule
